// File: rtl/cam_write_alloc_if.sv
`timescale 1ns/1ps
// Request/response handshake bundle for the CAM write/maintenance side.
interface cam_write_alloc_if #(
  parameter int KEY_W  = 4,
  parameter int ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [KEY_W-1:0]  req_key;
  logic              resp_valid;
  logic [1:0]        resp_status;
  logic [ADDR_W-1:0] resp_addr;

  modport master (
    output req_valid, req_op, req_key,
    input  req_ready, resp_valid, resp_status, resp_addr
  );

  modport slave (
    input  req_valid, req_op, req_key,
    output req_ready, resp_valid, resp_status, resp_addr
  );
endinterface

// File: rtl/cam_write_alloc.sv
`timescale 1ns/1ps
// CAM write side: owns keys/valid bits, handles insert/delete-by-key with
// lowest-free-slot allocation and a status/address response.
module cam_write_alloc #(
  parameter int ENTRIES = 8,
  parameter int KEY_W   = 4,
  parameter int ADDR_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  cam_write_alloc_if.slave         bus,
  output logic [ENTRIES*KEY_W-1:0] entry_key,
  output logic [ENTRIES-1:0]       entry_vld,
  output logic [ADDR_W:0]          count,
  output logic                     full,
  output logic                     empty
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT, S_RESP} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_DUP = 2'b01, ST_FULL = 2'b10, ST_NOTFOUND = 2'b11} status_t;

  state_t                          r_state;
  state_t                          w_next;
  logic                            r_op;
  logic [KEY_W-1:0]                r_key;
  logic [ENTRIES-1:0][KEY_W-1:0]   r_keys;
  logic [ENTRIES-1:0]              r_vld;
  logic [ADDR_W:0]                 r_count;
  logic                            r_any_hit;
  logic [ADDR_W-1:0]               r_hit_idx;
  logic                            r_any_free;
  logic [ADDR_W-1:0]               r_free_idx;
  logic                            r_resp_valid;
  status_t                         r_status;
  logic [ADDR_W-1:0]               r_addr;

  logic                            w_any_hit;
  logic [ADDR_W-1:0]               w_hit_idx;
  logic                            w_any_free;
  logic [ADDR_W-1:0]               w_free_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = S_SEARCH;
      end
      S_SEARCH: w_next = S_COMMIT;
      S_COMMIT: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // First-found wins, so scanning upward yields the lowest matching/free index.
  always_comb begin
    w_any_hit  = 1'b0;
    w_hit_idx  = '0;
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!w_any_hit && r_vld[i] && (r_keys[i] == r_key)) begin
        w_any_hit = 1'b1;
        w_hit_idx = ADDR_W'(i);
      end
      if (!w_any_free && !r_vld[i]) begin
        w_any_free = 1'b1;
        w_free_idx = ADDR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op         <= 1'b0;
      r_key        <= '0;
      r_keys       <= '0;
      r_vld        <= '0;
      r_count      <= '0;
      r_any_hit    <= 1'b0;
      r_hit_idx    <= '0;
      r_any_free   <= 1'b0;
      r_free_idx   <= '0;
      r_resp_valid <= 1'b0;
      r_status     <= ST_OK;
      r_addr       <= '0;
    end else begin
      // Registered strobe: high in the cycle following the RESP state.
      r_resp_valid <= (r_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op  <= bus.req_op;
            r_key <= bus.req_key;
          end
        end
        S_SEARCH: begin
          r_any_hit  <= w_any_hit;
          r_hit_idx  <= w_hit_idx;
          r_any_free <= w_any_free;
          r_free_idx <= w_free_idx;
        end
        S_COMMIT: begin
          if (!r_op) begin
            if (r_any_hit) begin
              r_status <= ST_DUP;
              r_addr   <= r_hit_idx;
            end else if (!r_any_free) begin
              r_status <= ST_FULL;
              r_addr   <= '0;
            end else begin
              r_keys[r_free_idx] <= r_key;
              r_vld[r_free_idx]  <= 1'b1;
              r_count            <= r_count + (ADDR_W+1)'(1);
              r_status           <= ST_OK;
              r_addr             <= r_free_idx;
            end
          end else begin
            if (r_any_hit) begin
              r_vld[r_hit_idx] <= 1'b0;
              r_count          <= r_count - (ADDR_W+1)'(1);
              r_status         <= ST_OK;
              r_addr           <= r_hit_idx;
            end else begin
              r_status <= ST_NOTFOUND;
              r_addr   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_status = r_status;
  assign bus.resp_addr   = r_addr;
  assign entry_key       = r_keys;
  assign entry_vld       = r_vld;
  assign count           = r_count;
  assign full            = (r_count == (ADDR_W+1)'(ENTRIES));
  assign empty           = (r_count == '0);

endmodule
